// File: rtl/stage_result_menu_if.sv
// stage_result_menu_if: control and pixel bundle between game FSM, keypad decoder and the stage-complete overlay
// enable/stage/x/y/key_pulse flow into the overlay; rgb/pix_on/sel/sel_valid flow back out
interface stage_result_menu_if;
  logic       enable;
  logic [3:0] stage;
  logic [9:0] x;
  logic [9:0] y;
  logic [4:0] key_pulse;
  logic [2:0] rgb;
  logic       pix_on;
  logic [1:0] sel;
  logic       sel_valid;
  modport master (output enable, stage, x, y, key_pulse, input rgb, pix_on, sel, sel_valid);
  modport slave  (input enable, stage, x, y, key_pulse, output rgb, pix_on, sel, sel_valid);
endinterface

// File: rtl/stage_result_menu.sv
// stage_result_menu: "<d> Stage Complete" overlay with NUM_OPT selectable options and a red selection box
// Ports: clk pixel clock; rst sync active-low reset; bus (slave) carries enable, stage, x, y, key_pulse in
//        and registered rgb, pix_on, sel, one-cycle sel_valid out. Pixel path latency is 2 clk.
// Optional: define MENU_BLINK_EN to blink the selection box every BLINK_FRAMES frames.
module font_rom_vhd (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  logic [127:0] g;
  always_comb
    case (addr[10:4])
      7'h30: g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      7'h31: g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      7'h32: g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      7'h33: g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      7'h34: g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      7'h35: g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      7'h36: g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      7'h37: g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      7'h38: g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      7'h39: g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      7'h3f: g = 128'h0000_7CC6_C60C_1818_1800_1818_0000_0000;
      7'h43: g = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
      7'h4d: g = 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000;
      7'h4e: g = 128'h0000_C6E6_F6FE_DECE_C6C6_C6C6_0000_0000;
      7'h52: g = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000;
      7'h53: g = 128'h0000_7CC6_C660_380C_06C6_C67C_0000_0000;
      7'h61: g = 128'h0000_0000_0078_0C7C_CCCC_CC76_0000_0000;
      7'h64: g = 128'h0000_1C0C_0C3C_6CCC_CCCC_CC76_0000_0000;
      7'h65: g = 128'h0000_0000_007C_C6FE_C0C0_C67C_0000_0000;
      7'h67: g = 128'h0000_0000_0076_CCCC_CCCC_CC7C_0CCC_7800;
      7'h6b: g = 128'h0000_E060_6066_6C78_786C_66E6_0000_0000;
      7'h6c: g = 128'h0000_3818_1818_1818_1818_183C_0000_0000;
      7'h6d: g = 128'h0000_0000_00EC_FED6_D6D6_D6C6_0000_0000;
      7'h6e: g = 128'h0000_0000_00DC_6666_6666_6666_0000_0000;
      7'h6f: g = 128'h0000_0000_007C_C6C6_C6C6_C67C_0000_0000;
      7'h70: g = 128'h0000_0000_00DC_6666_6666_667C_6060_F000;
      7'h72: g = 128'h0000_0000_00DC_7666_6060_60F0_0000_0000;
      7'h73: g = 128'h0000_0000_007C_C660_380C_C67C_0000_0000;
      7'h74: g = 128'h0000_1030_30FC_3030_3030_361C_0000_0000;
      7'h75: g = 128'h0000_0000_00CC_CCCC_CCCC_CC76_0000_0000;
      7'h78: g = 128'h0000_0000_00C6_6C38_3838_6CC6_0000_0000;
      default: g = '0;
    endcase
  // row 0 sits in the top byte of each glyph word
  always_ff @(posedge clk) data <= g[{~addr[3:0], 3'b000} +: 8];
endmodule

module stage_result_menu #(
  parameter int         NUM_OPT      = 3,
  parameter int         TITLE_X      = 260,
  parameter int         TITLE_Y      = 100,
  parameter int         OPT_X0       = 200,
  parameter int         OPT_Y        = 340,
  parameter int         OPT_PITCH    = 100,
  parameter logic [4:0] KEY_NEXT     = 5'h1e,
  parameter logic [4:0] KEY_PREV     = 5'h1c,
  parameter logic [4:0] KEY_OK       = 5'h1d,
  parameter int         BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst,
  stage_result_menu_if.slave bus
);
  if (NUM_OPT < 2 || NUM_OPT > 4 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("stage_result_menu: NUM_OPT must be 2..4 and BLINK_FRAMES >= 1");
  end
  typedef enum logic [1:0] {OFF, ARM, ACTIVE, DONE} state_t;
  localparam logic [1:0] LAST = 2'(NUM_OPT - 1);
  function automatic logic [9:0] opt_w(input logic [1:0] i);
    return i == 2'd0 ? 10'd56 : i == 2'd2 ? 10'd40 : 10'd32;
  endfunction
  function automatic logic [6:0] opt_char(input logic [1:0] i, input logic [2:0] k);
    logic [55:0] s;
    s = i == 2'd0 ? "Restart" : i == 2'd1 ? "Menu   " : i == 2'd2 ? "Sdoku  " : "Next   ";
    return s[{3'd6 - k, 3'b000} +: 7];
  endfunction
  function automatic logic [6:0] title_char(input logic [3:0] k, input logic [3:0] d);
    logic [127:0] s;
    s = "  Stage Complete";
    return k == 4'd0 ? (d > 4'd9 ? 7'h3f : 7'h30 + 7'(d)) : s[{~k, 3'b000} +: 7];
  endfunction
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic sel_valid_q, sel_valid_d, blink_on;
  logic [9:0] tdx, tdy, ody, odx, x1_q, y1_q, bx, by, bw;
  logic t_on, o_on, text_q, show_q, box_en_q, text_px, box_px, pix_on_q;
  logic [6:0] o_char, chr;
  logic [2:0] o_col, col_q, rgb_q;
  logic [7:0] glyph_row;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    sel_valid_d = 1'b0;
    case (state_q)
      OFF: begin
        state_d = ARM;
        sel_d = 2'd0;
      end
      ARM: state_d = ACTIVE;
      ACTIVE: begin
        sel_d = bus.key_pulse == KEY_NEXT ? (sel_q == LAST ? 2'd0 : sel_q + 2'd1) :
                bus.key_pulse == KEY_PREV ? (sel_q == 2'd0 ? LAST : sel_q - 2'd1) : sel_q;
        sel_valid_d = bus.key_pulse == KEY_OK;
        state_d = bus.key_pulse == KEY_OK ? DONE : ACTIVE;
      end
      default: ;
    endcase
    // dropping enable overrides everything, including a coincident confirm
    if (!bus.enable) begin
      state_d = OFF;
      sel_d = sel_q;
      sel_valid_d = 1'b0;
    end
  end
`ifdef MENU_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_FRAMES);
  logic [BW-1:0] blink_q, blink_d;
  // restart on ARM entry so the box shows as soon as the menu appears
  assign blink_d = (state_q == OFF && bus.enable) ? '0 :
                   (bus.x == '0 && bus.y == '0) ? (blink_q == BW'(2 * BLINK_FRAMES - 1) ? '0 : blink_q + BW'(1)) : blink_q;
  assign blink_on = blink_q < BW'(BLINK_FRAMES);
  always_ff @(posedge clk) blink_q <= !rst ? '0 : blink_d;
`else
  assign blink_on = 1'b1;
`endif
  // unsigned wrap makes each "offset < width" test a full two-sided range check
  assign tdx = bus.x - 10'(TITLE_X);
  assign tdy = bus.y - 10'(TITLE_Y);
  assign ody = bus.y - 10'(OPT_Y);
  assign t_on = tdx < 10'd128 && tdy < 10'd16;
  always_comb begin
    o_on = 1'b0;
    o_char = 7'h20;
    o_col = 3'd0;
    odx = '0;
    for (int i = 0; i < NUM_OPT; i++) begin
      odx = bus.x - 10'(OPT_X0 + i * OPT_PITCH);
      if (ody < 10'd16 && odx < opt_w(2'(i))) begin
        o_on = 1'b1;
        o_char = opt_char(2'(i), odx[5:3]);
        o_col = odx[2:0];
      end
    end
  end
  assign chr = t_on ? title_char(tdx[6:3], bus.stage) : o_char;
  font_rom_vhd u_font (.clk(clk), .addr({chr, t_on ? tdy[3:0] : ody[3:0]}), .data(glyph_row));
  // 2 px frame: outer edge 7 px and inner edge 5 px away from the selected label
  assign bw = opt_w(sel_q);
  assign bx = x1_q - (10'(OPT_X0 - 7) + 10'(OPT_PITCH) * {8'd0, sel_q});
  assign by = y1_q - 10'(OPT_Y - 7);
  assign box_px = box_en_q && bx < bw + 10'd14 && by < 10'd30 &&
                  !((bx - 10'd2) < bw + 10'd10 && (by - 10'd2) < 10'd26);
  assign text_px = text_q && glyph_row[~col_q];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= OFF;
      sel_q <= 2'd0;
      sel_valid_q <= 1'b0;
      col_q <= 3'd0;
      text_q <= 1'b0;
      show_q <= 1'b0;
      box_en_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      rgb_q <= 3'b111;
      pix_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      sel_valid_q <= sel_valid_d;
      col_q <= t_on ? tdx[2:0] : o_col;
      text_q <= t_on || o_on;
      show_q <= state_q == ACTIVE || state_q == DONE;
      box_en_q <= blink_on && (state_q == ACTIVE || (state_q == DONE && sel_valid_q));
      x1_q <= bus.x;
      y1_q <= bus.y;
      rgb_q <= !show_q ? 3'b111 : text_px ? 3'b001 : box_px ? 3'b100 : 3'b111;
      pix_on_q <= show_q && (text_px || box_px);
    end
  end
  assign bus.sel = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.rgb = rgb_q;
  assign bus.pix_on = pix_on_q;
endmodule
